// File: rtl/cpu_trace_fifo.sv
// Trace capture FIFO: records {seq, pc, instruction} on each entry into CAPTURE_STATE.
// Optional macro TRACE_OVERWRITE_EN makes a full FIFO overwrite its oldest entry instead of dropping.
module cpu_trace_fifo #(
    parameter int         DEPTH         = 8,
    parameter int         ADDR_W        = 3,
    parameter logic [1:0] CAPTURE_STATE = 2'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture_en,
    input  logic [1:0]        current_state,
    input  logic [2:0]        pc,
    input  logic [15:0]       raw_instruction,
    input  logic              trace_ready,
    input  logic              clear_overflow,
    output logic              trace_valid,
    output logic [22:0]       trace_data,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [7:0]        drop_count
);

    logic [22:0]     r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [ADDR_W:0] r_count;
    logic [3:0]      r_seq;
    logic            r_prev_hit;
    logic            r_overflow;
    logic [7:0]      r_drop_count;

    logic w_hit, w_capture, w_full, w_pop, w_push, w_drop, w_rd_adv;

    assign w_hit     = (current_state == CAPTURE_STATE);
    assign w_capture = capture_en & w_hit & ~r_prev_hit;
    assign w_full    = (r_count == (ADDR_W+1)'(DEPTH));
    assign w_pop     = (r_count != '0) & trace_ready;
    // A full FIFO that is also popping this cycle always has room for the capture.
    assign w_drop    = w_capture & w_full & ~w_pop;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_push   = 1'b0;
        w_rd_adv = w_pop;
`ifdef TRACE_OVERWRITE_EN
        w_push   = w_capture;
        w_rd_adv = w_pop | w_drop;
`else
        w_push   = w_capture & ~w_drop;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_seq        <= '0;
            r_prev_hit   <= 1'b0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_prev_hit <= w_hit;
            if (w_capture)
                r_seq <= r_seq + 4'd1;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_adv)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_rd_adv)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_rd_adv)
                r_count <= r_count - 1'b1;
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 8'hFF)
                    r_drop_count <= r_drop_count + 8'd1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // NOTE: the storage array is not reset; only pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {r_seq, pc, raw_instruction};
    end

    assign trace_valid = (r_count != '0);
    assign trace_data  = r_mem[r_rd_ptr];
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign drop_count  = r_drop_count;

endmodule

// File: tb/tb_cpu_trace_fifo.sv
// Self-checking bench for cpu_trace_fifo: directed test-plan scenarios plus random
// stimulus compared each cycle against a queue-based reference model.
module tb_cpu_trace_fifo;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        capture_en;
    logic [1:0]  current_state;
    logic [2:0]  pc;
    logic [15:0] raw_instruction;
    logic        trace_ready;
    logic        clear_overflow;
    logic        trace_valid;
    logic [22:0] trace_data;
    logic [ADDR_W:0] count;
    logic        overflow;
    logic [7:0]  drop_count;

    always #5 clk = ~clk;

    cpu_trace_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CAPTURE_STATE(2'd0)) dut (
        .clk(clk), .rst(rst), .capture_en(capture_en), .current_state(current_state),
        .pc(pc), .raw_instruction(raw_instruction), .trace_ready(trace_ready),
        .clear_overflow(clear_overflow), .trace_valid(trace_valid), .trace_data(trace_data),
        .count(count), .overflow(overflow), .drop_count(drop_count)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: a queue of entries plus the trace bookkeeping.
    logic [22:0] m_q[$];
    logic [3:0]  m_seq;
    bit          m_prev;
    bit          m_ovf;
    int          m_drop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_seq  = '0;
        m_prev = 1'b0;
        m_ovf  = 1'b0;
        m_drop = 0;
    endtask

    task automatic model_edge();
        bit hit, cap, pop, lost;
        hit  = (current_state == 2'd0);
        cap  = capture_en && hit && !m_prev;
        pop  = (m_q.size() != 0) && trace_ready;
        lost = 1'b0;
        if (pop) void'(m_q.pop_front());
        if (cap) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back({m_seq, pc, raw_instruction});
            end else begin
                lost = 1'b1;
`ifdef TRACE_OVERWRITE_EN
                void'(m_q.pop_front());
                m_q.push_back({m_seq, pc, raw_instruction});
`endif
            end
            m_seq = m_seq + 4'd1;
        end
        if (lost) begin
            m_ovf = 1'b1;
            if (m_drop < 255) m_drop++;
        end else if (clear_overflow) begin
            m_ovf = 1'b0;
        end
        m_prev = hit;
    endtask

    task automatic compare_all();
        check("count", 32'(count), 32'(m_q.size()));
        check("valid", 32'(trace_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check("data", 32'(trace_data), 32'(m_q[0]));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("drop_count", 32'(drop_count), 32'(m_drop));
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic set_state(input logic [1:0] s);
        current_state = s;
        cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    logic [3:0] exp_head;

    initial begin
        rst = 1'b1; capture_en = 1'b1; current_state = 2'd1; pc = 3'd1;
        raw_instruction = 16'hA5A5; trace_ready = 1'b0; clear_overflow = 1'b0;
        model_reset();
        #12;
        check("reset_count", 32'(count), 32'd0);
        check("reset_valid", 32'(trace_valid), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_drop", 32'(drop_count), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // State walk 0->1->2->3->0 produces seq 0 then seq 1.
        set_state(2'd0);
        check("walk_count1", 32'(count), 32'd1);
        check("walk_data1", 32'(trace_data), 32'({4'd0, 3'd1, 16'hA5A5}));
        set_state(2'd1); set_state(2'd2); set_state(2'd3); set_state(2'd0);
        check("walk_count2", 32'(count), 32'd2);

        // Dwelling in the capture state yields a single entry.
        set_state(2'd1);
        for (int i = 0; i < 5; i++) set_state(2'd0);
        check("dwell_count", 32'(count), 32'd3);

        // Drain, then verify disabled capture neither records nor bumps seq.
        trace_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_state(2'd1);
        trace_ready = 1'b0;
        capture_en = 1'b0;
        for (int i = 0; i < 3; i++) begin set_state(2'd0); set_state(2'd1); end
        check("disabled_count", 32'(count), 32'd0);
        capture_en = 1'b1;
        set_state(2'd0);
        check("seq_after_disable", 32'(trace_data[22:19]), 32'd3);

        // Ten captures into an 8-deep FIFO with no consumer.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            raw_instruction = 16'(i);
            set_state(2'd0); set_state(2'd2);
        end
        check("ovf_count", 32'(count), 32'd8);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_drop", 32'(drop_count), 32'd2);
`ifdef TRACE_OVERWRITE_EN
        exp_head = 4'd2;
`else
        exp_head = 4'd0;
`endif
        check("ovf_head_seq", 32'(trace_data[22:19]), 32'(exp_head));

        clear_overflow = 1'b1;
        set_state(2'd1);
        clear_overflow = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Full FIFO, capture and pop together.
        trace_ready = 1'b1;
        set_state(2'd0);
        trace_ready = 1'b0;
        check("fullpop_count", 32'(count), 32'd8);
        check("fullpop_ovf", 32'(overflow), 32'd0);
        check("fullpop_head", 32'(trace_data[22:19]), 32'(exp_head + 4'd1));

        // Drop to five entries, then reset asynchronously between edges.
        trace_ready = 1'b1;
        for (int i = 0; i < 3; i++) set_state(2'd1);
        trace_ready = 1'b0;
        check("pre_reset_count", 32'(count), 32'd5);
        current_state = 2'd0;
        #2;
        rst = 1'b1;
        #1;
        check("async_count", 32'(count), 32'd0);
        check("async_valid", 32'(trace_valid), 32'd0);
        check("async_drop", 32'(drop_count), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        set_state(2'd0);
        check("post_reset_seq", 32'(trace_data[22:19]), 32'd0);
        check("post_reset_count", 32'(count), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            current_state   = 2'($urandom_range(0, 3));
            capture_en      = ($urandom_range(0, 9) != 0);
            trace_ready     = ($urandom_range(0, 3) == 0);
            clear_overflow  = ($urandom_range(0, 15) == 0);
            pc              = 3'($urandom);
            raw_instruction = 16'($urandom);
            if ((i % 600) > 400) trace_ready = ($urandom_range(0, 1) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
